// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: control-word layout, register
// index width, FSM state encoding and the load-use detection helper.
package hazard_sequencer_pkg;

  localparam int REG_W             = 5;
  localparam int CONTROL_SIZE      = 8;
  localparam int CTRL_MEMREAD_BIT  = 3;
  localparam int CTRL_BRANCH_BIT   = 5;
  localparam int CTRL_REGWRITE_BIT = 6;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } seq_state_e;

  // A load in EX whose destination feeds a source of the instruction in ID; $zero never hazards.
  function automatic logic is_load_use(
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rt
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_sequencer_stats.sv
// Saturating event counter with enable and synchronous clear, used for the
// optional statistics outputs of hazard_sequencer.
module hazard_stats_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: load-use bubble insertion and fetch freeze
// while a branch resolves. Define HAZARD_STATS_EN to add statistics counters.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_branch_valid,
  input  logic             mem_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             ctrl_bubble,
  output logic             busy,
  output logic             wait_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall,
  output logic [STAT_W-1:0] stat_wait,
  output logic [STAT_W-1:0] stat_taken
`endif
);

  localparam logic [WAIT_W-1:0] LAST_CNT = WAIT_W'(MAX_WAIT - 1);

  seq_state_e        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              load_use_s;

  assign load_use_s = is_load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; a branch in ID yields to a concurrent load-use stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (ext_stall) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!load_use_s && id_is_branch) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_WAIT: begin
          if (mem_branch_valid) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q == LAST_CNT) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WAIT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pipeline controls; a flush always writes the NOP into IF/ID.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    ctrl_bubble = 1'b0;
    busy        = (state_q == ST_WAIT);
    if (!rst_n) begin
      busy = 1'b0;
    end else if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use_s) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_bubble = 1'b1;
          end else if (id_is_branch) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        ST_WAIT: begin
          pc_write    = mem_branch_valid || (cnt_q == LAST_CNT);
          ifid_flush  = 1'b1;
          ctrl_bubble = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

  assign wait_timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  logic run_live_s, wait_live_s;
  assign run_live_s  = !ext_stall && (state_q == ST_RUN);
  assign wait_live_s = !ext_stall && (state_q == ST_WAIT);

  hazard_stats_counter #(.W(STAT_W)) u_stat_stall (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(run_live_s && load_use_s), .count_o(stat_stall)
  );
  hazard_stats_counter #(.W(STAT_W)) u_stat_wait (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(wait_live_s), .count_o(stat_wait)
  );
  hazard_stats_counter #(.W(STAT_W)) u_stat_taken (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(wait_live_s && mem_branch_valid && mem_branch_taken), .count_o(stat_taken)
  );
`endif

endmodule
